// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - two-port (CPU/DMA) arbiter for a single external RAM port
// Optional feature macro: ARB_RR_EN (round-robin tie-break; fixed CPU priority when undefined)
module mem_bus_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 8,
  parameter int RAM_LAT = 1
) (
  input  logic              clk_in,
  input  logic              reset_in,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  output logic              cpu_stall,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_ack,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              ram_wr,
  output logic              ram_oe,
  output logic              owner,
  output logic              busy
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_ACK    = 2'd2
  } state_t;

  // Counter reload: RAM_LAT access cycles means RAM_LAT-1 down to 0.
  localparam logic [3:0] CNT_INIT = 4'(RAM_LAT - 1);

  state_t            state;
  logic [3:0]        cnt;
  logic              win;
  logic              any_req;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  assign any_req   = cpu_req | dma_req;
  assign busy      = (state != ST_IDLE);
  assign cpu_stall = cpu_req & ~cpu_ack;

`ifdef ARB_RR_EN
  // prio holds the port that wins the next tie (0 = C, 1 = D).
  logic prio;

  // Ties go to prio; a lone requester always wins.
  assign win = (cpu_req & dma_req) ? prio : ~cpu_req;

  // Hand the tie-break to the loser of every grant.
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      prio <= 1'b0;
    end else if (state == ST_IDLE && any_req) begin
      prio <= ~win;
    end
  end
`else
  // Fixed priority: D only wins when C is not asking.
  assign win = ~cpu_req;
`endif

  assign sel_we    = win ? dma_we    : cpu_we;
  assign sel_addr  = win ? dma_addr  : cpu_addr;
  assign sel_wdata = win ? dma_wdata : cpu_wdata;

  // Transfer sequencer: grant/latch in IDLE, hold strobes in ACCESS, pulse ack in ACK.
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      state     <= ST_IDLE;
      cnt       <= 4'd0;
      owner     <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      ram_wr    <= 1'b0;
      ram_oe    <= 1'b0;
      cpu_ack   <= 1'b0;
      dma_ack   <= 1'b0;
      cpu_rdata <= '0;
      dma_rdata <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            owner     <= win;
            ram_addr  <= sel_addr;
            ram_wdata <= sel_we ? sel_wdata : '0;
            ram_wr    <= sel_we;
            ram_oe    <= ~sel_we;
            cnt       <= CNT_INIT;
            state     <= ST_ACCESS;
          end else begin
            ram_addr  <= '0;
            ram_wdata <= '0;
          end
        end
        ST_ACCESS: begin
          if (cnt == 4'd0) begin
            // ram_oe doubles as the latched "this is a read" flag.
            if (ram_oe) begin
              if (owner) dma_rdata <= ram_rdata;
              else       cpu_rdata <= ram_rdata;
            end
            ram_wr  <= 1'b0;
            ram_oe  <= 1'b0;
            cpu_ack <= ~owner;
            dma_ack <= owner;
            state   <= ST_ACK;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_ACK: begin
          cpu_ack   <= 1'b0;
          dma_ack   <= 1'b0;
          ram_addr  <= '0;
          ram_wdata <= '0;
          state     <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - self-checking bench for mem_bus_arbiter (RAM_LAT 1 and 3 instances)
module tb_mem_bus_arbiter;

`ifdef ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk_in = 1'b0;
  logic        reset_in = 1'b0;
  logic        cpu_req = 1'b0, cpu_we = 1'b0, dma_req = 1'b0, dma_we = 1'b0;
  logic [15:0] cpu_addr = '0, dma_addr = '0;
  logic [7:0]  cpu_wdata = '0, dma_wdata = '0, ram_rdata = '0;

  logic [7:0]  a_crd, a_drd, a_rwd, b_crd, b_drd, b_rwd;
  logic [15:0] a_radr, b_radr;
  logic        a_cack, a_cst, a_dack, a_wr, a_oe, a_own, a_busy;
  logic        b_cack, b_cst, b_dack, b_wr, b_oe, b_own, b_busy;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk_in = ~clk_in;

  mem_bus_arbiter #(.ADDR_W(16), .DATA_W(8), .RAM_LAT(1)) u1 (
    .clk_in(clk_in), .reset_in(reset_in),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(a_crd), .cpu_ack(a_cack), .cpu_stall(a_cst),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_rdata(a_drd), .dma_ack(a_dack),
    .ram_addr(a_radr), .ram_wdata(a_rwd), .ram_rdata(ram_rdata),
    .ram_wr(a_wr), .ram_oe(a_oe), .owner(a_own), .busy(a_busy));

  mem_bus_arbiter #(.ADDR_W(16), .DATA_W(8), .RAM_LAT(3)) u3 (
    .clk_in(clk_in), .reset_in(reset_in),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(b_crd), .cpu_ack(b_cack), .cpu_stall(b_cst),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_rdata(b_drd), .dma_ack(b_dack),
    .ram_addr(b_radr), .ram_wdata(b_rwd), .ram_rdata(ram_rdata),
    .ram_wr(b_wr), .ram_oe(b_oe), .owner(b_own), .busy(b_busy));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // Transaction-level reference: rem counts cycles left in the current transfer
  // (LAT access cycles followed by one ack cycle); 0 means idle.
  typedef struct packed {
    logic [4:0]  rem;
    logic        own;
    logic        we;
    logic [15:0] addr;
    logic [7:0]  wd;
    logic        prio;
    logic [7:0]  crd;
    logic [7:0]  drd;
  } mst_t;

  mst_t m1 = '0;
  mst_t m3 = '0;

  function automatic mst_t mstep(input mst_t s, input int lat, input logic [7:0] rd);
    mst_t n;
    logic w;
    n = s;
    if (s.rem == 5'd0) begin
      if (cpu_req || dma_req) begin
        if (cpu_req && dma_req) w = RR ? s.prio : 1'b0;
        else w = dma_req;
        n.own  = w;
        n.we   = w ? dma_we : cpu_we;
        n.addr = w ? dma_addr : cpu_addr;
        n.wd   = w ? dma_wdata : cpu_wdata;
        n.rem  = 5'(lat + 1);
        if (RR) n.prio = ~w;
      end
    end else begin
      if (s.rem == 5'd2 && !s.we) begin
        if (s.own) n.drd = rd;
        else n.crd = rd;
      end
      n.rem = s.rem - 5'd1;
    end
    return n;
  endfunction

  function automatic logic [63:0] mout(input mst_t s, input logic creq);
    logic bz, acc, ak;
    bz  = (s.rem != 5'd0);
    acc = (s.rem > 5'd1);
    ak  = (s.rem == 5'd1);
    return {17'd0, bz ? s.addr : 16'd0, (bz && s.we) ? s.wd : 8'd0,
            acc && s.we, acc && !s.we, bz && s.own, bz,
            ak && !s.own, ak && s.own, s.crd, s.drd, creq && !(ak && !s.own)};
  endfunction

  always @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      m1 <= '0;
      m3 <= '0;
    end else begin
      m1 <= mstep(m1, 1, ram_rdata);
      m3 <= mstep(m3, 3, ram_rdata);
    end
  end

  // Every cycle, both instances must match the reference on all outputs.
  always @(negedge clk_in) begin
    chk("model_lat1", {17'd0, a_radr, a_rwd, a_wr, a_oe, a_busy & a_own, a_busy,
                       a_cack, a_dack, a_crd, a_drd, a_cst}, mout(m1, cpu_req));
    chk("model_lat3", {17'd0, b_radr, b_rwd, b_wr, b_oe, b_busy & b_own, b_busy,
                       b_cack, b_dack, b_crd, b_drd, b_cst}, mout(m3, cpu_req));
  end

  typedef struct packed {
    logic        req, we;
    logic [15:0] addr;
    logic [7:0]  wd, rrd;
    logic        e_wr, e_oe, e_ack, e_busy;
    logic [15:0] e_addr;
    logic [7:0]  e_wd, e_crd;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int oe_cnt, ack_cnt, ngrant;
    logic got, prev_busy;
    logic [3:0] seq, exp_seq;

    tbl[0] = {1'b1, 1'b1, 16'h1234, 8'hA5, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, 16'h1234, 8'hA5, 8'h00};
    tbl[1] = {1'b1, 1'b1, 16'h1234, 8'hA5, 8'h3C, 1'b0, 1'b0, 1'b1, 1'b1, 16'h1234, 8'hA5, 8'h00};
    tbl[2] = {1'b1, 1'b0, 16'h00FF, 8'h00, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 8'h00};
    tbl[3] = {1'b1, 1'b0, 16'h00FF, 8'h00, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b1, 16'h00FF, 8'h00, 8'h00};
    tbl[4] = {1'b1, 1'b0, 16'h00FF, 8'h00, 8'h3C, 1'b0, 1'b0, 1'b1, 1'b1, 16'h00FF, 8'h00, 8'h3C};
    tbl[5] = {1'b0, 1'b0, 16'h0000, 8'h00, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 8'h3C};

    // Reset held with a pending CPU request.
    cpu_req = 1'b1;
    repeat (3) tick();
    chk("rst_busy", 64'(a_busy), 64'd0);
    chk("rst_strobes", {62'd0, a_wr, a_oe}, 64'd0);
    chk("rst_addr", 64'(a_radr), 64'd0);
    chk("rst_acks", {62'd0, a_cack, a_dack}, 64'd0);
    chk("rst_rdata", {48'd0, a_crd, a_drd}, 64'd0);
    reset_in = 1'b1;
    tick();
    chk("rst_first_grant", {62'd0, a_busy, a_own}, 64'b10);
    cpu_req = 1'b0;
    repeat (6) tick();

    // Table: C write then C read on the RAM_LAT=1 instance.
    for (int i = 0; i < 6; i++) begin
      cpu_req = tbl[i].req; cpu_we = tbl[i].we; cpu_addr = tbl[i].addr;
      cpu_wdata = tbl[i].wd; ram_rdata = tbl[i].rrd;
      tick();
      chk($sformatf("tbl%0d_strobes", i), {62'd0, a_wr, a_oe}, {62'd0, tbl[i].e_wr, tbl[i].e_oe});
      chk($sformatf("tbl%0d_ack_busy", i), {62'd0, a_cack, a_busy}, {62'd0, tbl[i].e_ack, tbl[i].e_busy});
      chk($sformatf("tbl%0d_bus", i), {40'd0, a_radr, a_rwd}, {40'd0, tbl[i].e_addr, tbl[i].e_wd});
      chk($sformatf("tbl%0d_crd", i), 64'(a_crd), 64'(tbl[i].e_crd));
    end
    repeat (6) tick();

    // D read on the RAM_LAT=3 instance.
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 16'h0100; ram_rdata = 8'h5A;
    oe_cnt = 0; got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      if (b_oe) oe_cnt++;
      if (b_dack) begin
        got = 1'b1;
        dma_req = 1'b0;
        chk("dread_rdata", 64'(b_drd), 64'h5A);
      end
    end
    chk("dread_ack_seen", 64'(got), 64'd1);
    chk("dread_oe_cycles", 64'(oe_cnt), 64'd3);
    chk("dread_crd_kept", 64'(b_crd), 64'(m3.crd));
    dma_req = 1'b0;
    repeat (8) tick();

    // Both ports requesting continuously on the RAM_LAT=1 instance.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h2000;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 16'h3000;
    ngrant = 0; seq = '0; prev_busy = a_busy;
    for (int i = 0; i < 40 && ngrant < 4; i++) begin
      tick();
      if (a_busy && !prev_busy) begin
        seq[ngrant] = a_own;
        ngrant++;
      end
      prev_busy = a_busy;
    end
    exp_seq = RR ? 4'b1010 : 4'b0000;
    chk("both_grant_count", 64'(ngrant), 64'd4);
    chk("both_owner_seq", 64'(seq), 64'(exp_seq));
    cpu_req = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      if (a_busy && !prev_busy) begin
        got = 1'b1;
        chk("d_after_c_drop", 64'(a_own), 64'd1);
      end
      prev_busy = a_busy;
    end
    chk("d_after_c_drop_seen", 64'(got), 64'd1);
    dma_req = 1'b0;
    repeat (8) tick();

    // Reset during the second of three ACCESS cycles.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h4444;
    tick();
    chk("midrst_oe_first", 64'(b_oe), 64'd1);
    tick();
    chk("midrst_oe_second", 64'(b_oe), 64'd1);
    reset_in = 1'b0;
    #1;
    chk("midrst_oe_drop", {62'd0, b_oe, b_busy}, 64'd0);
    cpu_req = 1'b0;
    repeat (2) tick();
    reset_in = 1'b1;
    ack_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (b_cack) ack_cnt++;
    end
    chk("midrst_no_ack", 64'(ack_cnt), 64'd0);

    // D read whose request drops in the first ACCESS cycle.
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 16'h0200; ram_rdata = 8'hC3;
    tick();
    chk("drop_oe", 64'(b_oe), 64'd1);
    dma_req = 1'b0;
    ack_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (b_dack) ack_cnt++;
    end
    chk("drop_ack_once", 64'(ack_cnt), 64'd1);
    chk("drop_rdata", 64'(b_drd), 64'hC3);

    // Random traffic, checked every cycle against the reference.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(3) == 0) cpu_req = 1'($urandom_range(1));
      if ($urandom_range(3) == 0) dma_req = 1'($urandom_range(1));
      if ($urandom_range(3) == 0) begin
        cpu_we = 1'($urandom); cpu_addr = 16'($urandom); cpu_wdata = 8'($urandom);
      end
      if ($urandom_range(3) == 0) begin
        dma_we = 1'($urandom); dma_addr = 16'($urandom); dma_wdata = 8'($urandom);
      end
      ram_rdata = 8'($urandom);
      if (i == 1500) reset_in = 1'b0;
      if (i == 1502) reset_in = 1'b1;
      tick();
    end

    #2;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
